bla_frame_writer: RTL and testbench

Downstream stage of the Bresenham line-draw wrapper. When the wrapper pulses `bla_done`, this block snapshots the 4096-bit (64×64) `line_buffer` bitmap and streams it to frame-buffer memory as 128 32-bit words over a ready-gated write port. It sits between the line-draw wrapper and the frame-buffer SRAM controller. It can optionally skip all-zero words to save memory bandwidth.

---
 rtl/bla_frame_writer.sv | 99 +++++++++
 tb/tb_bla_frame_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bla_frame_writer.sv
// Streams a captured 64x64 line-draw bitmap to frame-buffer memory as 128 32-bit words.
// Optionally skips all-zero words; flags bla_done pulses that arrive while a frame is in flight.
module bla_frame_writer #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned BASE_ADDR = 0,
   parameter bit          SKIP_ZERO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bla_done,
   input  logic [4095:0]     line_buffer,
   input  logic              mem_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun
);

   localparam int unsigned WORDS  = 128;
   localparam int unsigned IDX_W  = 7;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BMP_W  = 4096;

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [BMP_W-1:0]   snapshot;

   assign idx_nxt = idx + 1'b1;

   function automatic logic [WORD_W-1:0] word_at(input logic [BMP_W-1:0] bmp,
                                                 input logic [IDX_W-1:0] i);
      return bmp[{i, 5'd0} +: WORD_W];
   endfunction

   function automatic logic [ADDR_W-1:0] addr_at(input logic [IDX_W-1:0] i);
      return ADDR_W'(BASE_ADDR) + ADDR_W'(i);
   endfunction

   // A word is issued as a write unless zero-skipping applies to it.
   function automatic logic issue(input logic [WORD_W-1:0] w);
      return !(SKIP_ZERO && (w == '0));
   endfunction

   // Outputs always describe the word at idx; they only move on a transfer or a skip.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         snapshot   <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= ADDR_W'(BASE_ADDR);
         wr_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (bla_done && (state != IDLE)) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (bla_done) begin
                  snapshot <= line_buffer;
                  idx      <= '0;
                  wr_addr  <= addr_at('0);
                  wr_data  <= word_at(line_buffer, '0);
                  wr_en    <= issue(word_at(line_buffer, '0));
                  busy     <= 1'b1;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               if (!wr_en || mem_ready) begin
                  if (idx == IDX_W'(WORDS - 1)) begin
                     wr_en      <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx     <= idx_nxt;
                     wr_addr <= addr_at(idx_nxt);
                     wr_data <= word_at(snapshot, idx_nxt);
                     wr_en   <= issue(word_at(snapshot, idx_nxt));
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bla_frame_writer.sv
// Scoreboard bench for bla_frame_writer: two instances (plain, and zero-skipping with a wrapping base)
// share stimulus; a frame-level model predicts every write and its cycle plus the frame_done cycle.
module tb_bla_frame_writer;

   localparam logic [15:0] BASE0 = 16'h0100;
   localparam logic [15:0] BASE1 = 16'hFFC0;

   logic          clk = 1'b0;
   logic          rst;
   logic          bla_done;
   logic          mem_ready;
   logic [4095:0] line_buffer;
   logic          wr_en      [2];
   logic [15:0]   wr_addr    [2];
   logic [31:0]   wr_data    [2];
   logic          busy       [2];
   logic          frame_done [2];
   logic          overrun    [2];

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t wq0[$];
   wr_t wq1[$];
   int  dq0[$];
   int  dq1[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   bit  rdy [1024];

   logic        st_pend [2];
   logic [15:0] st_addr [2];
   logic [31:0] st_data [2];

   bla_frame_writer #(.ADDR_W(16), .BASE_ADDR(32'h0100), .SKIP_ZERO(1'b0)) u_plain (
      .clk(clk), .rst(rst), .bla_done(bla_done), .line_buffer(line_buffer),
      .mem_ready(mem_ready), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
      .busy(busy[0]), .frame_done(frame_done[0]), .overrun(overrun[0]));

   bla_frame_writer #(.ADDR_W(16), .BASE_ADDR(32'hFFC0), .SKIP_ZERO(1'b1)) u_skip (
      .clk(clk), .rst(rst), .bla_done(bla_done), .line_buffer(line_buffer),
      .mem_ready(mem_ready), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
      .busy(busy[1]), .frame_done(frame_done[1]), .overrun(overrun[1]));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] base_of(input int d);
      return (d == 0) ? BASE0 : BASE1;
   endfunction

   function automatic bit pop_w(input int d, output wr_t e);
      e = '{addr: 16'h0, data: 32'h0, cyc: 0};
      if (d == 0) begin
         if (wq0.size() == 0) return 1'b0;
         e = wq0.pop_front();
      end else begin
         if (wq1.size() == 0) return 1'b0;
         e = wq1.pop_front();
      end
      return 1'b1;
   endfunction

   function automatic bit pop_d(input int d, output int c);
      c = 0;
      if (d == 0) begin
         if (dq0.size() == 0) return 1'b0;
         c = dq0.pop_front();
      end else begin
         if (dq1.size() == 0) return 1'b0;
         c = dq1.pop_front();
      end
      return 1'b1;
   endfunction

   // Monitor: compares transfers and frame_done against the scoreboard, and checks stall stability.
   always @(negedge clk) begin
      wr_t e;
      int  c;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (st_pend[d])
            check($sformatf("stall_hold%0d", d), 64'({wr_en[d], wr_addr[d], wr_data[d]}),
                  64'({1'b1, st_addr[d], st_data[d]}));
         if (wr_en[d] && mem_ready) begin
            if (pop_w(d, e))
               check($sformatf("write%0d", d), {wr_addr[d], wr_data[d], 16'(cyc)},
                     {e.addr, e.data, 16'(e.cyc)});
            else begin
               total++; bad++;
               $display("FAIL extra_write%0d cyc=%0d actual addr=%0h data=%0h required none",
                        d, cyc, wr_addr[d], wr_data[d]);
            end
         end
         st_pend[d] = wr_en[d] && !mem_ready && !rst;
         st_addr[d] = wr_addr[d];
         st_data[d] = wr_data[d];
         if (frame_done[d]) begin
            if (pop_d(d, c))
               check($sformatf("frame_done_cyc%0d", d), 64'(cyc), 64'(c));
            else begin
               total++; bad++;
               $display("FAIL extra_frame_done%0d cyc=%0d actual=1 required=0", d, cyc);
            end
         end
      end
   end

   // One frame: model the expected stream, then drive bla_done and the mem_ready pattern.
   task automatic run_frame(input logic [4095:0] bm, input int mode, input int ovr_at,
                            input logic [4095:0] alt, input bit iso, input int rst_at);
      int          t, k, last, c;
      logic [31:0] w;
      @(posedge clk); #1;
      for (int i = 0; i < 1024; i++)
         rdy[i] = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 2) == 0) : ($urandom_range(3) != 0);
      t    = cyc + 1;
      last = 0;
      for (int d = 0; d < 2; d++) begin
         k = 0;
         for (int i = 0; i < 128; i++) begin
            w = bm[32*i +: 32];
            if (d == 1 && w == 32'h0) k++;
            else begin
               while (!rdy[k]) k++;
               if (d == 0) wq0.push_back('{addr: 16'(base_of(d) + 16'(i)), data: w, cyc: t + 1 + k});
               else        wq1.push_back('{addr: 16'(base_of(d) + 16'(i)), data: w, cyc: t + 1 + k});
               k++;
            end
         end
         if (d == 0) dq0.push_back(t + 1 + k); else dq1.push_back(t + 1 + k);
         if (t + 1 + k > last) last = t + 1 + k;
      end
      bla_done    = 1'b1;
      line_buffer = bm;
      @(posedge clk); #1;
      c = t + 1;
      if (iso) line_buffer = '1;
      forever begin
         mem_ready = rdy[c - t - 1];
         bla_done  = (ovr_at != 0) && (c == t + ovr_at);
         if (bla_done) line_buffer = alt;
         rst = (rst_at != 0) && (c == t + rst_at);
         if (c == t + 1)
            for (int d = 0; d < 2; d++) check($sformatf("busy_start%0d", d), 64'(busy[d]), 64'(1));
         if (ovr_at != 0 && c == t + ovr_at)
            for (int d = 0; d < 2; d++) check($sformatf("ovr_before%0d", d), 64'(overrun[d]), 64'(0));
         if (ovr_at != 0 && c == t + ovr_at + 1)
            for (int d = 0; d < 2; d++) check($sformatf("ovr_set%0d", d), 64'(overrun[d]), 64'(1));
         if (rst_at != 0 && c == t + rst_at + 1) begin
            wq0.delete(); wq1.delete(); dq0.delete(); dq1.delete();
            for (int d = 0; d < 2; d++)
               check($sformatf("mid_reset%0d", d),
                     64'({wr_en[d], busy[d], overrun[d], frame_done[d], wr_addr[d], wr_data[d]}),
                     64'({4'b0000, base_of(d), 32'h0}));
         end
         if (rst_at != 0 && c == t + rst_at + 5) break;
         if (rst_at == 0 && c >= last + 2) break;
         @(posedge clk); #1;
         c++;
      end
      bla_done = 1'b0;
      rst      = 1'b0;
      if (rst_at == 0)
         for (int d = 0; d < 2; d++) begin
            check($sformatf("left_writes%0d", d), 64'((d == 0) ? wq0.size() : wq1.size()), 64'(0));
            check($sformatf("left_done%0d", d), 64'((d == 0) ? dq0.size() : dq1.size()), 64'(0));
            check($sformatf("idle_after%0d", d), 64'(busy[d]), 64'(0));
            if (ovr_at != 0) check($sformatf("ovr_sticky%0d", d), 64'(overrun[d]), 64'(1));
         end
   endtask

   function automatic logic [4095:0] sparse_bm();
      logic [4095:0] b;
      b = '0;
      for (int i = 0; i < 128; i++)
         if ($urandom_range(1) == 1) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   initial begin
      logic [4095:0] diag, corners, r1, r2;
      rst = 1'b1; bla_done = 1'b0; mem_ready = 1'b0; line_buffer = '0;
      for (int d = 0; d < 2; d++) begin st_pend[d] = 1'b0; st_addr[d] = '0; st_data[d] = '0; end
      diag = '0;
      for (int y = 0; y < 64; y++) diag[64*y + y] = 1'b1;
      corners = '0;
      corners[0]    = 1'b1;
      corners[4095] = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
         check($sformatf("reset_state%0d", d),
               64'({wr_en[d], busy[d], overrun[d], frame_done[d], wr_addr[d], wr_data[d]}),
               64'({4'b0000, base_of(d), 32'h0}));
      @(posedge clk); #1;
      rst = 1'b0;

      run_frame(diag, 0, 0, '0, 1'b0, 0);
      run_frame(diag, 1, 0, '0, 1'b0, 0);
      run_frame(corners, 0, 0, '0, 1'b0, 0);
      run_frame('0, 0, 0, '0, 1'b1, 0);
      r1 = sparse_bm();
      r2 = ~r1;
      run_frame(r1, 2, 50, r2, 1'b0, 0);
      run_frame(diag, 0, 0, '0, 1'b0, 40);
      run_frame(diag, 0, 0, '0, 1'b0, 0);
      run_frame(sparse_bm(), 2, 0, '0, 1'b0, 0);
      run_frame(sparse_bm(), 2, 0, '0, 1'b0, 0);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
